// File: rtl/memgame_pkg.sv
// Shared types and helpers for the memory-game pattern player.
package memgame_pkg;

   localparam int LFSR_W = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEAD = 3'd1,
      SHOW = 3'd2,
      GAP  = 3'd3,
      DONE = 3'd4
   } state_e;

   // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (shift right, feedback into MSB).
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[LFSR_W-1:1]};
   endfunction

   // Two-bit colour index to one-hot LED drive.
   function automatic logic [3:0] colour_led(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

endpackage

// File: rtl/toggle_edge_det.sv
// Turns every level change of the pacing toggle into a one-cycle tick.
module toggle_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_toggle,
   output logic o_tick
);

   logic prev_q;

   // Remember last cycle's toggle level; updated unconditionally so stale edges age out.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= i_toggle;
      end
   end

   assign o_tick = i_toggle ^ prev_q;

endmodule

// File: rtl/pattern_player.sv
// Replays an LFSR-derived colour sequence on four one-hot LEDs, paced by toggle ticks.
module pattern_player
   import memgame_pkg::*;
#(
   parameter int              MAX_LEN   = 32,
   parameter int              LEN_W     = $clog2(MAX_LEN + 1),
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_toggle,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_reseed,
   output logic             o_cnt_en,
   output logic [3:0]       o_led,
   output logic [LEN_W-1:0] o_step,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_e              state_q,  state_d;
   logic [LFSR_W-1:0]   seed_q,   seed_d;
   logic [LFSR_W-1:0]   lfsr_q,   lfsr_d;
   logic [LEN_W-1:0]    len_q,    len_d;
   logic [LEN_W-1:0]    step_q,   step_d;
   logic [3:0]          led_q,    led_d;
   logic                cnt_en_q, cnt_en_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;

   logic                tick_s;
   logic [LEN_W-1:0]    len_clamp_s;
   logic [LEN_W-1:0]    last_step_s;

   toggle_edge_det u_edge (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_toggle (i_toggle),
      .o_tick   (tick_s)
   );

   assign len_clamp_s = (i_len > MAX_LEN_L) ? MAX_LEN_L : i_len;
   assign last_step_s = len_q - LEN_W'(1);

   // State and output registers; reset returns to a dark, idle player with the default seed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         seed_q   <= LFSR_SEED;
         lfsr_q   <= LFSR_SEED;
         len_q    <= '0;
         step_q   <= '0;
         led_q    <= 4'b0000;
         cnt_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         lfsr_q   <= lfsr_d;
         len_q    <= len_d;
         step_q   <= step_d;
         led_q    <= led_d;
         cnt_en_q <= cnt_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic: each tick advances exactly one phase; ticks outside playback are ignored.
   always_comb begin
      state_d  = state_q;
      seed_d   = seed_q;
      lfsr_d   = lfsr_q;
      len_d    = len_q;
      step_d   = step_q;
      led_d    = led_q;
      cnt_en_d = cnt_en_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               lfsr_d = seed_q;
               len_d  = len_clamp_s;
               step_d = '0;
               led_d  = 4'b0000;
               if (len_clamp_s == '0) begin
                  // Nothing to show: skip pacing entirely and just report completion.
                  cnt_en_d = 1'b0;
                  state_d  = DONE;
               end else begin
                  cnt_en_d = 1'b1;
                  state_d  = LEAD;
               end
            end else if (i_reseed) begin
               seed_d = lfsr_next(seed_q);
            end else begin
               seed_d = seed_q;
            end
         end
         LEAD: begin
            if (tick_s) begin
               led_d   = colour_led(lfsr_q[1:0]);
               lfsr_d  = lfsr_next(lfsr_q);
               state_d = SHOW;
            end else begin
               state_d = LEAD;
            end
         end
         SHOW: begin
            if (tick_s) begin
               led_d   = 4'b0000;
               state_d = GAP;
            end else begin
               state_d = SHOW;
            end
         end
         GAP: begin
            if (tick_s) begin
               if (step_q == last_step_s) begin
                  cnt_en_d = 1'b0;
                  state_d  = DONE;
               end else begin
                  step_d  = step_q + LEN_W'(1);
                  led_d   = colour_led(lfsr_q[1:0]);
                  lfsr_d  = lfsr_next(lfsr_q);
                  state_d = SHOW;
               end
            end else begin
               state_d = GAP;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            led_d    = 4'b0000;
            cnt_en_d = 1'b0;
            state_d  = IDLE;
         end
      endcase

      busy_d = (state_d == LEAD) || (state_d == SHOW) || (state_d == GAP);
   end

   assign o_cnt_en = cnt_en_q;
   assign o_led    = led_q;
   assign o_step   = step_q;
   assign o_busy   = busy_q;
   assign o_done   = done_q;

endmodule
